// File: rtl/pheap_cmd_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pheap_cmd_queue: client command FIFO, pheap issue control, result buffer    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+

package pheapTypes;
  typedef enum logic {
    LEQ = 1'b0,
    DEQ = 1'b1
  } opcode_t;
endpackage

module pheap_cmd_queue #(
  parameter int FIFO_DEPTH = 8,
  parameter int HEAP_CAP   = 15,
  parameter int RES_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  pheapTypes::opcode_t               in_op,
  input  logic [31:0]                       in_pri,
  output logic                              heap_valid,
  output pheapTypes::opcode_t               heap_op,
  output logic [31:0]                       heap_pri,
  input  logic                              heap_rdy,
  input  logic [31:0]                       heap_pri_out,
  input  logic                              heap_valid_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [31:0]                       out_pri,
  output logic                              err_full,
  output logic                              err_empty,
  output logic [$clog2(HEAP_CAP+1)-1:0]     occupancy
);

  localparam int c_faw = $clog2(FIFO_DEPTH);
  localparam int c_raw = $clog2(RES_DEPTH);
  localparam int c_ow  = $clog2(HEAP_CAP + 1);

  localparam logic [c_faw:0]   c_fdepth = FIFO_DEPTH[c_faw:0];
  localparam logic [c_faw:0]   c_f1     = 1;
  localparam logic [c_raw:0]   c_rdepth = RES_DEPTH[c_raw:0];
  localparam logic [c_raw:0]   c_r1     = 1;
  localparam logic [c_ow-1:0]  c_cap    = HEAP_CAP[c_ow-1:0];
  localparam logic [c_ow-1:0]  c_o1     = 1;

  logic [32:0]          r_fmem [FIFO_DEPTH];
  logic [c_faw:0]       r_fwr;
  logic [c_faw:0]       r_frd;
  logic [31:0]          r_rmem [RES_DEPTH];
  logic [c_raw:0]       r_rwr;
  logic [c_raw:0]       r_rrd;
  logic [c_raw:0]       r_outst;
  logic [c_ow-1:0]      r_occ;
  logic                 r_init;
  logic                 r_heap_valid;
  pheapTypes::opcode_t  r_heap_op;
  logic [31:0]          r_heap_pri;
  logic                 r_err_full;
  logic                 r_err_empty;

  logic [c_faw:0]       w_fcount;
  logic                 w_fempty;
  logic                 w_ffull;
  logic                 w_wr;
  logic [32:0]          w_head;
  pheapTypes::opcode_t  w_head_op;
  logic [c_raw:0]       w_rcount;
  logic [c_raw:0]       w_credits;
  logic                 w_can_issue;
  logic                 w_iss_leq;
  logic                 w_iss_deq;
  logic                 w_drop_full;
  logic                 w_drop_empty;
  logic                 w_pop;
  logic                 w_rpush;
  logic                 w_rpop;

  assign w_fcount  = r_fwr - r_frd;
  assign w_fempty  = (w_fcount == '0);
  assign w_ffull   = (w_fcount == c_fdepth);
  assign in_ready  = r_init && !w_ffull;
  assign w_wr      = in_valid && in_ready;
  assign w_head    = r_fmem[r_frd[c_faw-1:0]];
  assign w_head_op = pheapTypes::opcode_t'(w_head[32]);

  // Credits reserve result-buffer space for every DEQ in flight.
  assign w_rcount  = r_rwr - r_rrd;
  assign w_credits = c_rdepth - (w_rcount + r_outst);

  assign w_can_issue = !w_fempty && heap_rdy && !r_heap_valid;

  always_comb begin
    w_iss_leq    = 1'b0;
    w_iss_deq    = 1'b0;
    w_drop_full  = 1'b0;
    w_drop_empty = 1'b0;
    if (w_can_issue) begin
      if (w_head_op == pheapTypes::LEQ) begin
        if (r_occ < c_cap) w_iss_leq = 1'b1;
        else               w_drop_full = 1'b1;
      end else if (r_occ == '0) begin
        w_drop_empty = 1'b1;
      end else if (w_credits != '0) begin
        w_iss_deq = 1'b1;
      end
    end
  end

  assign w_pop   = w_iss_leq | w_iss_deq | w_drop_full | w_drop_empty;
  assign w_rpush = heap_valid_out && (r_outst != '0);
  assign w_rpop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fwr        <= '0;
      r_frd        <= '0;
      r_rwr        <= '0;
      r_rrd        <= '0;
      r_outst      <= '0;
      r_occ        <= '0;
      r_init       <= 1'b0;
      r_heap_valid <= 1'b0;
      r_heap_op    <= pheapTypes::LEQ;
      r_heap_pri   <= '0;
      r_err_full   <= 1'b0;
      r_err_empty  <= 1'b0;
    end else begin
      r_init       <= 1'b1;
      r_heap_valid <= w_iss_leq | w_iss_deq;
      r_err_full   <= w_drop_full;
      r_err_empty  <= w_drop_empty;
      if (w_wr)    r_fwr <= r_fwr + c_f1;
      if (w_pop)   r_frd <= r_frd + c_f1;
      if (w_rpush) r_rwr <= r_rwr + c_r1;
      if (w_rpop)  r_rrd <= r_rrd + c_r1;
      if (w_iss_leq) begin
        r_heap_op  <= pheapTypes::LEQ;
        r_heap_pri <= w_head[31:0];
        r_occ      <= r_occ + c_o1;
      end else if (w_iss_deq) begin
        r_heap_op  <= pheapTypes::DEQ;
        r_heap_pri <= '0;
        r_occ      <= r_occ - c_o1;
      end
      case ({w_iss_deq, w_rpush})
        2'b10:   r_outst <= r_outst + c_r1;
        2'b01:   r_outst <= r_outst - c_r1;
        default: r_outst <= r_outst;
      endcase
    end
  end

  // Storage arrays need no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr)    r_fmem[r_fwr[c_faw-1:0]] <= {in_op, in_pri};
    if (w_rpush) r_rmem[r_rwr[c_raw-1:0]] <= heap_pri_out;
  end

  assign heap_valid = r_heap_valid;
  assign heap_op    = r_heap_op;
  assign heap_pri   = r_heap_pri;
  assign err_full   = r_err_full;
  assign err_empty  = r_err_empty;
  assign occupancy  = r_occ;
  assign out_valid  = (w_rcount != '0);
  assign out_pri    = out_valid ? r_rmem[r_rrd[c_raw-1:0]] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_pheap_cmd_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pheap_cmd_queue: directed self-checking bench for pheap_cmd_queue        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_pheap_cmd_queue;
  import pheapTypes::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  opcode_t     in_op;
  logic [31:0] in_pri;
  logic        heap_valid;
  opcode_t     heap_op;
  logic [31:0] heap_pri;
  logic        heap_rdy;
  logic [31:0] heap_pri_out = 32'h0;
  logic        heap_valid_out = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pri;
  logic        err_full;
  logic        err_empty;
  logic [3:0]  occupancy;

  int          checks = 0;
  int          errors = 0;
  logic        model_en = 1'b0;
  logic        late_req = 1'b0;
  logic [31:0] model_val = 32'h1;

  pheap_cmd_queue #(.FIFO_DEPTH(8), .HEAP_CAP(15), .RES_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pri(in_pri),
    .heap_valid(heap_valid), .heap_op(heap_op), .heap_pri(heap_pri), .heap_rdy(heap_rdy),
    .heap_pri_out(heap_pri_out), .heap_valid_out(heap_valid_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_pri(out_pri),
    .err_full(err_full), .err_empty(err_empty), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Heap model: answers each DEQ strobe one cycle later with an incrementing value.
  always @(negedge clk) begin
    if (late_req) begin
      heap_valid_out = 1'b1;
      heap_pri_out   = 32'hEE;
    end else if (model_en && heap_valid && heap_op == DEQ) begin
      heap_valid_out = 1'b1;
      heap_pri_out   = model_val;
      model_val      = model_val + 32'h1;
    end else begin
      heap_valid_out = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input opcode_t op, input logic [31:0] p);
    in_valid = v;
    in_op    = op;
    in_pri   = p;
  endtask

  task automatic cyc(input string tag, input logic hv, input logic ef, input logic ee);
    tick();
    chk({tag, ".heap_valid"}, 32'(heap_valid), 32'(hv));
    chk({tag, ".err_full"},   32'(err_full),   32'(ef));
    chk({tag, ".err_empty"},  32'(err_empty),  32'(ee));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, ".in_ready"},   32'(in_ready),   32'h0);
    chk({tag, ".heap_valid"}, 32'(heap_valid), 32'h0);
    chk({tag, ".heap_op"},    32'(heap_op),    32'(LEQ));
    chk({tag, ".heap_pri"},   heap_pri,        32'h0);
    chk({tag, ".out_valid"},  32'(out_valid),  32'h0);
    chk({tag, ".out_pri"},    out_pri,         32'h0);
    chk({tag, ".err_full"},   32'(err_full),   32'h0);
    chk({tag, ".err_empty"},  32'(err_empty),  32'h0);
    chk({tag, ".occupancy"},  32'(occupancy),  32'h0);
  endtask

  initial begin
    rst = 1'b0; heap_rdy = 1'b0; out_ready = 1'b0;
    drive(1'b0, LEQ, 32'h0);
    repeat (2) tick();
    reset_checks("rst");
    rst = 1'b1;
    chk("release.in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("init.in_ready", 32'(in_ready), 32'h1);

    // DEQ on an empty heap is dropped with err_empty
    heap_rdy = 1'b1;
    drive(1'b1, DEQ, 32'h0);
    cyc("e0", 1'b0, 1'b0, 1'b0);
    drive(1'b0, LEQ, 32'h0);
    cyc("e1", 1'b0, 1'b0, 1'b1);
    chk("e1.occupancy", 32'(occupancy), 32'h0);
    cyc("e2", 1'b0, 1'b0, 1'b0);

    // Three enqueues, spaced by one idle cycle, in order
    drive(1'b1, LEQ, 32'h10); cyc("a1", 1'b0, 1'b0, 1'b0);
    drive(1'b1, LEQ, 32'h05); cyc("a2", 1'b1, 1'b0, 1'b0);
    chk("a2.heap_pri", heap_pri, 32'h10);
    chk("a2.heap_op", 32'(heap_op), 32'(LEQ));
    chk("a2.occupancy", 32'(occupancy), 32'h1);
    drive(1'b1, LEQ, 32'h20); cyc("a3", 1'b0, 1'b0, 1'b0);
    drive(1'b0, LEQ, 32'h0);  cyc("a4", 1'b1, 1'b0, 1'b0);
    chk("a4.heap_pri", heap_pri, 32'h05);
    cyc("a5", 1'b0, 1'b0, 1'b0);
    cyc("a6", 1'b1, 1'b0, 1'b0);
    chk("a6.heap_pri", heap_pri, 32'h20);
    chk("a6.occupancy", 32'(occupancy), 32'h3);
    cyc("a7", 1'b0, 1'b0, 1'b0);
    chk("a7.heap_pri_hold", heap_pri, 32'h20);

    // Fill the FIFO while the heap is busy
    heap_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, LEQ, 32'h31 + 32'(i));
      cyc("b.fill", 1'b0, 1'b0, 1'b0);
      chk("b.in_ready", 32'(in_ready), (i < 7) ? 32'h1 : 32'h0);
    end
    drive(1'b1, LEQ, 32'h99);
    cyc("b.over", 1'b0, 1'b0, 1'b0);
    chk("b.over.in_ready", 32'(in_ready), 32'h0);
    drive(1'b0, LEQ, 32'h0);
    heap_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc("b.issue", 1'b1, 1'b0, 1'b0);
      chk("b.issue.heap_pri", heap_pri, 32'h31 + 32'(i));
      chk("b.issue.in_ready", 32'(in_ready), 32'h1);
      cyc("b.gap", 1'b0, 1'b0, 1'b0);
    end
    cyc("b.drained", 1'b0, 1'b0, 1'b0);
    chk("b.occupancy", 32'(occupancy), 32'd11);

    // Fill heap to capacity, then one more enqueue is dropped
    drive(1'b1, LEQ, 32'h41); cyc("c1", 1'b0, 1'b0, 1'b0);
    drive(1'b1, LEQ, 32'h42); cyc("c2", 1'b1, 1'b0, 1'b0);
    drive(1'b1, LEQ, 32'h43); cyc("c3", 1'b0, 1'b0, 1'b0);
    drive(1'b1, LEQ, 32'h44); cyc("c4", 1'b1, 1'b0, 1'b0);
    drive(1'b1, LEQ, 32'hAA); cyc("c5", 1'b0, 1'b0, 1'b0);
    drive(1'b0, LEQ, 32'h0);  cyc("c6", 1'b1, 1'b0, 1'b0);
    cyc("c7", 1'b0, 1'b0, 1'b0);
    cyc("c8", 1'b1, 1'b0, 1'b0);
    chk("c8.heap_pri", heap_pri, 32'h44);
    chk("c8.occupancy", 32'(occupancy), 32'd15);
    cyc("c9", 1'b0, 1'b0, 1'b0);
    cyc("c10", 1'b0, 1'b1, 1'b0);
    cyc("c11", 1'b0, 1'b0, 1'b0);
    chk("c11.occupancy", 32'(occupancy), 32'd15);

    // Five dequeues with a blocked result port: the fifth waits for credit
    model_en = 1'b1;
    drive(1'b1, DEQ, 32'hDEAD);
    cyc("d1", 1'b0, 1'b0, 1'b0);
    cyc("d2", 1'b1, 1'b0, 1'b0);
    chk("d2.heap_op", 32'(heap_op), 32'(DEQ));
    chk("d2.heap_pri", heap_pri, 32'h0);
    cyc("d3", 1'b0, 1'b0, 1'b0);
    cyc("d4", 1'b1, 1'b0, 1'b0);
    cyc("d5", 1'b0, 1'b0, 1'b0);
    drive(1'b0, LEQ, 32'h0);
    cyc("d6", 1'b1, 1'b0, 1'b0);
    cyc("d7", 1'b0, 1'b0, 1'b0);
    cyc("d8", 1'b1, 1'b0, 1'b0);
    cyc("d9", 1'b0, 1'b0, 1'b0);
    cyc("d10", 1'b0, 1'b0, 1'b0);
    cyc("d11", 1'b0, 1'b0, 1'b0);
    chk("d11.occupancy", 32'(occupancy), 32'd11);
    chk("d11.out_valid", 32'(out_valid), 32'h1);
    chk("d11.out_pri", out_pri, 32'h01);
    out_ready = 1'b1;
    cyc("d12", 1'b0, 1'b0, 1'b0);
    chk("d12.out_pri", out_pri, 32'h02);
    cyc("d13", 1'b1, 1'b0, 1'b0);
    chk("d13.heap_op", 32'(heap_op), 32'(DEQ));
    chk("d13.out_pri", out_pri, 32'h03);
    chk("d13.occupancy", 32'(occupancy), 32'd10);
    cyc("d14", 1'b0, 1'b0, 1'b0);
    chk("d14.out_pri", out_pri, 32'h04);
    cyc("d15", 1'b0, 1'b0, 1'b0);
    chk("d15.out_valid", 32'(out_valid), 32'h1);
    chk("d15.out_pri", out_pri, 32'h05);
    cyc("d16", 1'b0, 1'b0, 1'b0);
    chk("d16.out_valid", 32'(out_valid), 32'h0);
    chk("d16.out_pri", out_pri, 32'h0);

    // Reset with three commands queued and one DEQ outstanding
    model_en = 1'b0; out_ready = 1'b0;
    drive(1'b1, DEQ, 32'h0);  cyc("r1", 1'b0, 1'b0, 1'b0);
    drive(1'b1, LEQ, 32'h51); cyc("r2", 1'b1, 1'b0, 1'b0);
    chk("r2.heap_op", 32'(heap_op), 32'(DEQ));
    heap_rdy = 1'b0;
    drive(1'b1, LEQ, 32'h52); cyc("r3", 1'b0, 1'b0, 1'b0);
    drive(1'b1, LEQ, 32'h53); cyc("r4", 1'b0, 1'b0, 1'b0);
    drive(1'b0, LEQ, 32'h0);
    rst = 1'b0;
    #1;
    reset_checks("midrst");
    tick();
    rst = 1'b1; heap_rdy = 1'b1; late_req = 1'b1;
    tick();
    late_req = 1'b0;
    chk("x0.in_ready", 32'(in_ready), 32'h1);
    chk("x0.out_valid", 32'(out_valid), 32'h0);
    chk("x0.occupancy", 32'(occupancy), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc("x", 1'b0, 1'b0, 1'b0);
      chk("x.out_valid", 32'(out_valid), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
